// File: rtl/mnk_board_game.sv
// mnk_board_game: ROWS x COLS board, two players (X, O), first to WIN_LEN marks in a line wins.
// States INI/STA/XTU/OTU/CHK/DONE. The result is checked in CHK, the cycle after a mark is placed.
// Scores saturate at all-ones. The Board output is held in DONE so the display can show it.
// Optional feature: define ALT_FIRST_EN to swap the starting player on every rematch.
module mnk_board_game #(
    parameter int ROWS    = 3,
    parameter int COLS    = 3,
    parameter int WIN_LEN = 3,
    parameter int SCORE_W = 12
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic                     Ack,
    input  logic                     Lbtn,
    input  logic                     Rbtn,
    input  logic                     Ubtn,
    input  logic                     Dbtn,
    input  logic                     Cbtn,
    output logic                     Qi,
    output logic                     Qs,
    output logic                     Qx,
    output logic                     Qo,
    output logic                     Qc,
    output logic                     Qd,
    output logic                     Xwins,
    output logic                     Owins,
    output logic                     Draw,
    output logic [SCORE_W-1:0]       P1s,
    output logic [SCORE_W-1:0]       P2s,
    output logic [2:0]               CurRow,
    output logic [2:0]               CurCol,
    output logic [2*ROWS*COLS-1:0]   Board
);
    localparam logic [2:0] INI  = 3'd0;
    localparam logic [2:0] STA  = 3'd1;
    localparam logic [2:0] XTU  = 3'd2;
    localparam logic [2:0] OTU  = 3'd3;
    localparam logic [2:0] CHK  = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    localparam int         CELLS  = ROWS * COLS;
    localparam int         GR     = ROWS + WIN_LEN;      // padded grid rows
    localparam int         GC     = COLS + 2 * WIN_LEN;  // padded grid cols, board starts at WIN_LEN
    localparam logic [6:0] FULL   = 7'(CELLS);
    localparam logic [2:0] LAST_R = 3'(ROWS - 1);
    localparam logic [2:0] LAST_C = 3'(COLS - 1);

    logic [2:0] state;
    logic [6:0] move_cnt;
    logic       o_moved;        // 1 when the mark being checked belongs to O
    logic [6:0] cur_idx;
    logic [1:0] cur_cell;
    logic [1:0] my_code;
    logic [1:0] chk_code;
    logic       win;
    logic [1:0] grid [GR][GC];
`ifdef ALT_FIRST_EN
    logic       starter_o;      // 1 when O opens the next game
`endif

    assign Qi = (state == INI);
    assign Qs = (state == STA);
    assign Qx = (state == XTU);
    assign Qo = (state == OTU);
    assign Qc = (state == CHK);
    assign Qd = (state == DONE);

    assign my_code  = (state == OTU) ? 2'b10 : 2'b01;
    assign chk_code = o_moved ? 2'b10 : 2'b01;

    // Select the cell under the cursor
    always_comb begin
        // NOTE: each always_comb output gets a default before any conditional write so no latch is inferred.
        cur_cell = 2'b00;
        cur_idx  = 7'(CurRow) * 7'(COLS) + 7'(CurCol);
        for (int i = 0; i < CELLS; i++)
            if (7'(i) == cur_idx) cur_cell = Board[2*i +: 2];
    end

    // Scan every run of WIN_LEN cells for the player who just moved. The grid is padded with empty
    // cells, so runs that leave the board read as empty and never count as a win.
    always_comb begin : win_scan
        logic h, v, d, a;
        win = 1'b0;
        for (int r = 0; r < GR; r++)
            for (int c = 0; c < GC; c++)
                grid[r][c] = 2'b00;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                grid[r][c+WIN_LEN] = Board[2*(r*COLS+c) +: 2];
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                h = 1'b1; v = 1'b1; d = 1'b1; a = 1'b1;
                for (int k = 0; k < WIN_LEN; k++) begin
                    h = h & (grid[r][c+WIN_LEN+k]   == chk_code);
                    v = v & (grid[r+k][c+WIN_LEN]   == chk_code);
                    d = d & (grid[r+k][c+WIN_LEN+k] == chk_code);
                    a = a & (grid[r+k][c+WIN_LEN-k] == chk_code);
                end
                win = win | h | v | d | a;
            end
    end

    // Game FSM: board, cursor, move count, result flags and scores
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            state    <= INI;
            // NOTE: Board is a small register array, not a RAM, so it is cleared with the rest of the state.
            Board    <= '0;
            CurRow   <= 3'd0;
            CurCol   <= 3'd0;
            move_cnt <= 7'd0;
            o_moved  <= 1'b0;
            Xwins    <= 1'b0;
            Owins    <= 1'b0;
            Draw     <= 1'b0;
            P1s      <= '0;
            P2s      <= '0;
`ifdef ALT_FIRST_EN
            starter_o <= 1'b0;
`endif
        end else begin
            case (state)
                INI: begin
                    P1s <= '0;
                    P2s <= '0;
                    if (Start) state <= STA;
                end
                STA: begin
                    Board    <= '0;
                    CurRow   <= 3'd0;
                    CurCol   <= 3'd0;
                    move_cnt <= 7'd0;
                    Xwins    <= 1'b0;
                    Owins    <= 1'b0;
                    Draw     <= 1'b0;
`ifdef ALT_FIRST_EN
                    state    <= starter_o ? OTU : XTU;
`else
                    state    <= XTU;
`endif
                end
                XTU, OTU: begin
                    if (Cbtn) begin
                        if (cur_cell == 2'b00) begin
                            for (int i = 0; i < CELLS; i++)
                                if (7'(i) == cur_idx) Board[2*i +: 2] <= my_code;
                            move_cnt <= move_cnt + 7'd1;
                            o_moved  <= (state == OTU);
                            state    <= CHK;
                        end
                    end else if (Lbtn) CurCol <= (CurCol == 3'd0)   ? LAST_C : CurCol - 3'd1;
                    else if (Rbtn)     CurCol <= (CurCol == LAST_C) ? 3'd0   : CurCol + 3'd1;
                    else if (Ubtn)     CurRow <= (CurRow == 3'd0)   ? LAST_R : CurRow - 3'd1;
                    else if (Dbtn)     CurRow <= (CurRow == LAST_R) ? 3'd0   : CurRow + 3'd1;
                end
                CHK: begin
                    if (win) begin
                        if (o_moved) begin
                            Owins <= 1'b1;
                            if (P2s != '1) P2s <= P2s + SCORE_W'(1);
                        end else begin
                            Xwins <= 1'b1;
                            if (P1s != '1) P1s <= P1s + SCORE_W'(1);
                        end
                        state <= DONE;
                    end else if (move_cnt == FULL) begin
                        Draw  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= o_moved ? XTU : OTU;
                    end
                end
                DONE: begin
                    if (Ack) begin
                        state <= INI;
                        P1s   <= '0;
                        P2s   <= '0;
`ifdef ALT_FIRST_EN
                        starter_o <= 1'b0;
`endif
                    end else if (Cbtn) begin
                        state <= STA;
`ifdef ALT_FIRST_EN
                        starter_o <= ~starter_o;
`endif
                    end
                end
                default: state <= INI;
            endcase
        end
    end
endmodule

// File: tb/tb_mnk_board_game.sv
// Bench for mnk_board_game. Instance a is the default 3x3 board; instance b is 6x7 with
// WIN_LEN=4 and 2-bit scores. Both share the inputs. A reference model steps once per clock
// and every cycle is compared against the outputs of the instance under test.
module tb_mnk_board_game;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic Start = 1'b0, Ack = 1'b0, Lbtn = 1'b0, Rbtn = 1'b0, Ubtn = 1'b0, Dbtn = 1'b0, Cbtn = 1'b0;

    logic [5:0]  a_q, b_q;          // {Qi,Qs,Qx,Qo,Qc,Qd}
    logic [2:0]  a_f, b_f;          // {Xwins,Owins,Draw}
    logic [11:0] a_p1, a_p2;
    logic [1:0]  b_p1, b_p2;
    logic [2:0]  a_r, a_c, b_r, b_c;
    logic [17:0] a_board;
    logic [83:0] b_board;

    mnk_board_game dut_a (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
        .Lbtn(Lbtn), .Rbtn(Rbtn), .Ubtn(Ubtn), .Dbtn(Dbtn), .Cbtn(Cbtn),
        .Qi(a_q[5]), .Qs(a_q[4]), .Qx(a_q[3]), .Qo(a_q[2]), .Qc(a_q[1]), .Qd(a_q[0]),
        .Xwins(a_f[2]), .Owins(a_f[1]), .Draw(a_f[0]),
        .P1s(a_p1), .P2s(a_p2), .CurRow(a_r), .CurCol(a_c), .Board(a_board)
    );

    mnk_board_game #(.ROWS(6), .COLS(7), .WIN_LEN(4), .SCORE_W(2)) dut_b (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
        .Lbtn(Lbtn), .Rbtn(Rbtn), .Ubtn(Ubtn), .Dbtn(Dbtn), .Cbtn(Cbtn),
        .Qi(b_q[5]), .Qs(b_q[4]), .Qx(b_q[3]), .Qo(b_q[2]), .Qc(b_q[1]), .Qd(b_q[0]),
        .Xwins(b_f[2]), .Owins(b_f[1]), .Draw(b_f[0]),
        .P1s(b_p1), .P2s(b_p2), .CurRow(b_r), .CurCol(b_c), .Board(b_board)
    );

    always #5 Clk = ~Clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Button vector {Start,Ack,C,L,R,U,D}
    localparam logic [6:0] B_NONE  = 7'b0000000;
    localparam logic [6:0] B_START = 7'b1000000;
    localparam logic [6:0] B_ACK   = 7'b0100000;
    localparam logic [6:0] B_C     = 7'b0010000;
    localparam logic [6:0] B_L     = 7'b0001000;
    localparam logic [6:0] B_R     = 7'b0000100;
    localparam logic [6:0] B_U     = 7'b0000010;
    localparam logic [6:0] B_D     = 7'b0000001;

    int checks = 0;
    int errors = 0;

    // Reference model. mstate: 0 INI, 1 STA, 2 X turn, 3 O turn, 4 check, 5 done
    bit use_b = 1'b0;
    int rows = 3, cols = 3, wl = 3, smax = 4095;
    int mb [8][8];
    int mstate, mr, mc, mcnt, mover, p1, p2, xw, ow, dw, starter;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] obs_q();     return use_b ? 128'(b_q) : 128'(a_q); endfunction
    function automatic logic [127:0] obs_f();     return use_b ? 128'(b_f) : 128'(a_f); endfunction
    function automatic logic [127:0] obs_p1();    return use_b ? 128'(b_p1) : 128'(a_p1); endfunction
    function automatic logic [127:0] obs_p2();    return use_b ? 128'(b_p2) : 128'(a_p2); endfunction
    function automatic logic [127:0] obs_cur();   return use_b ? 128'({b_r, b_c}) : 128'({a_r, a_c}); endfunction
    function automatic logic [127:0] obs_board(); return use_b ? 128'(b_board) : 128'(a_board); endfunction

    function automatic logic [127:0] exp_board();
        logic [127:0] v = '0;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                v[2*(r*cols+c) +: 2] = 2'(mb[r][c]);
        return v;
    endfunction

    // Does player p own wl consecutive cells in any row, column or diagonal?
    function automatic bit model_win(input int p);
        int drs [4] = '{0, 1, 1, 1};
        int dcs [4] = '{1, 0, 1, -1};
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                for (int dir = 0; dir < 4; dir++) begin
                    bit run = 1'b1;
                    for (int k = 0; k < wl; k++) begin
                        int rr = r + k * drs[dir];
                        int cc = c + k * dcs[dir];
                        if (rr < 0 || rr >= rows || cc < 0 || cc >= cols) run = 1'b0;
                        else if (mb[rr][cc] != p) run = 1'b0;
                    end
                    if (run) return 1'b1;
                end
        return 1'b0;
    endfunction

    task automatic clear_board();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mb[r][c] = 0;
    endtask

    task automatic model_reset();
        clear_board();
        mstate = 0; mr = 0; mc = 0; mcnt = 0; mover = 1;
        p1 = 0; p2 = 0; xw = 0; ow = 0; dw = 0; starter = 0;
    endtask

    task automatic model_cycle(input logic [6:0] b);
        case (mstate)
            0: begin
                p1 = 0; p2 = 0;
                if (b[6]) mstate = 1;
            end
            1: begin
                clear_board();
                mr = 0; mc = 0; mcnt = 0; xw = 0; ow = 0; dw = 0;
                mstate = (starter != 0) ? 3 : 2;
            end
            2, 3: begin
                if (b[4]) begin
                    if (mb[mr][mc] == 0) begin
                        mover = (mstate == 2) ? 1 : 2;
                        mb[mr][mc] = mover;
                        mcnt++;
                        mstate = 4;
                    end
                end
                else if (b[3]) mc = (mc + cols - 1) % cols;
                else if (b[2]) mc = (mc + 1) % cols;
                else if (b[1]) mr = (mr + rows - 1) % rows;
                else if (b[0]) mr = (mr + 1) % rows;
            end
            4: begin
                if (model_win(mover)) begin
                    if (mover == 1) begin xw = 1; if (p1 < smax) p1++; end
                    else            begin ow = 1; if (p2 < smax) p2++; end
                    mstate = 5;
                end else if (mcnt == rows * cols) begin
                    dw = 1; mstate = 5;
                end else begin
                    mstate = (mover == 1) ? 3 : 2;
                end
            end
            default: begin
                if (b[5]) begin
                    mstate = 0; p1 = 0; p2 = 0; starter = 0;
                end else if (b[4]) begin
                    mstate = 1;
`ifdef ALT_FIRST_EN
                    starter = 1 - starter;
`endif
                end
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"}, obs_q(), 128'(6'b100000 >> mstate));
        check({tag, ".board"}, obs_board(), exp_board());
        check({tag, ".cursor"}, obs_cur(), 128'({3'(mr), 3'(mc)}));
        check({tag, ".flags"}, obs_f(), 128'({1'(xw), 1'(ow), 1'(dw)}));
        check({tag, ".p1s"}, obs_p1(), 128'(p1));
        check({tag, ".p2s"}, obs_p2(), 128'(p2));
    endtask

    task automatic cyc(input string tag, input logic [6:0] b);
        {Start, Ack, Cbtn, Lbtn, Rbtn, Ubtn, Dbtn} = b;
        @(posedge Clk); #1;
        {Start, Ack, Cbtn, Lbtn, Rbtn, Ubtn, Dbtn} = B_NONE;
        model_cycle(b);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        @(posedge Clk); #1;
        Reset = 1'b0;
        check_all({tag, ".rel"});
    endtask

    // Walk the cursor to (r,c) in a random direction; sometimes add lower-priority or ignored buttons.
    task automatic goto(input int r, input int c);
        logic [6:0] b;
        bit dir = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8 && mc != c; i++) begin
            b = dir ? B_L : B_R;
            if ($urandom_range(0, 1) == 1) b = b | (7'($urandom) & (dir ? 7'b1100111 : 7'b1100011));
            cyc("move_col", b);
        end
        dir = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8 && mr != r; i++) begin
            b = dir ? B_U : B_D;
            if ($urandom_range(0, 1) == 1) b = b | (7'($urandom) & (dir ? 7'b1100001 : 7'b1100000));
            cyc("move_row", b);
        end
    endtask

    task automatic place(input string tag, input int r, input int c);
        goto(r, c);
        cyc(tag, B_C);
        if (mstate == 4) cyc({tag, ".chk"}, B_NONE);
    endtask

    task automatic start_game();
        cyc("start", B_START);
        cyc("sta", B_NONE);
    endtask

    task automatic rematch();
        cyc("rematch", B_C);
        cyc("rematch_sta", B_NONE);
    endtask

    task automatic rand_game(input string tag);
        int q[$];
        int pick;
        for (int n = 0; n < 200 && mstate != 5; n++) begin
            q.delete();
            for (int r = 0; r < rows; r++)
                for (int c = 0; c < cols; c++)
                    if (mb[r][c] == 0) q.push_back(r * cols + c);
            if ($urandom_range(0, 3) == 0) pick = $urandom_range(0, rows * cols - 1);
            else                           pick = q[$urandom_range(0, q.size() - 1)];
            place(tag, pick / cols, pick % cols);
        end
        check({tag, ".done"}, obs_q(), 128'(6'b000001));
    endtask

    initial begin
        int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        int xs [4];
        int os [4];
        int xi, oi;

        // Reset values, 3x3 board
        do_reset("reset");
        start_game();

        // Cursor wrap and priority from (0,0)
        cyc("wrap_left", B_L);
        cyc("wrap_up", B_U);
        cyc("left_over_right", B_L | B_R);
        check("cursor_after_wrap", obs_cur(), 128'({3'd2, 3'd1}));

        // X wins on the top row; O first tries to mark X's cell
        place("x00", 0, 0);
        goto(0, 0);
        cyc("o_on_x_cell", B_C);
        check("occupied_state", obs_q(), 128'(6'b000100));
        place("o10", 1, 0);
        place("x01", 0, 1);
        place("o11", 1, 1);
        goto(0, 2);
        cyc("x02", B_C);
        check("x02_in_chk", obs_q(), 128'(6'b000010));
        cyc("x02_result", B_NONE);
        check("xwin_flags", obs_f(), 128'(3'b100));
        check("xwin_p1s", obs_p1(), 128'd1);
        cyc("done_ignores_move", B_L | B_R | B_U | B_D);

        // Rematch keeps scores; full board with no line is a draw
        rematch();
        for (int i = 0; i < 9; i++) place("draw", draw_seq[i] / 3, draw_seq[i] % 3);
        check("draw_flags", obs_f(), 128'(3'b001));
        check("draw_p1s", obs_p1(), 128'd1);

        // Ack beats Cbtn in DONE and clears the scores
        cyc("ack_over_c", B_ACK | B_C);
        check("ack_scores", obs_p1(), 128'd0);

        // Random games with rematches and one Ack in between
        start_game();
        for (int g = 0; g < 6; g++) begin
            rand_game("rand3");
            if (g == 2) begin
                cyc("ack", B_ACK);
                cyc("idle", B_NONE);
                start_game();
            end else begin
                rematch();
            end
        end

        // Reset in the middle of a turn
        place("pre_reset", 1, 1);
        do_reset("mid_reset");

        // 6x7 board, WIN_LEN=4, 2-bit scores
        use_b = 1'b1; rows = 6; cols = 7; wl = 4; smax = 3;
        do_reset("reset_b");
        start_game();
        xs = '{35, 37, 39, 41};      // (5,0) (5,2) (5,4) (5,6): no line
        os = '{3, 9, 15, 21};        // (0,3) (1,2) (2,1) (3,0): anti-diagonal
        xi = 0; oi = 0;
        for (int n = 0; n < 8 && mstate != 5; n++) begin
            if (mstate == 2) begin place("anti_x", xs[xi] / 7, xs[xi] % 7); xi++; end
            else             begin place("anti_o", os[oi] / 7, os[oi] % 7); oi++; end
        end
        check("owin_flags", obs_f(), 128'(3'b010));
        check("owin_p2s", obs_p2(), 128'd1);

        // Four X wins saturate the 2-bit score
        xs = '{0, 1, 2, 3};          // row 0
        os = '{14, 16, 18, 27};      // (2,0) (2,2) (2,4) (3,6): no line
        for (int g = 0; g < 4; g++) begin
            rematch();
            xi = 0; oi = 0;
            for (int n = 0; n < 8 && mstate != 5; n++) begin
                if (mstate == 2) begin place("sat_x", xs[xi] / 7, xs[xi] % 7); xi++; end
                else             begin place("sat_o", os[oi] / 7, os[oi] % 7); oi++; end
            end
        end
        check("sat_p1s", obs_p1(), 128'd3);
        check("sat_p2s", obs_p2(), 128'd1);

        rematch();
        rand_game("rand67");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
